cacheline_arbiter: RTL and testbench
====================================

Name: cacheline_arbiter

Overview:
- Shares the single 256-bit physical-memory port between the instruction cache (read-only) and the data cache (read and write-back).
- Sits between both caches' pmem_* interfaces and the cacheline adaptor/burst memory.
- Serves one full-line transaction at a time and latches the winner's request so memory sees stable signals.
- Routes response and read data only to the granted requester.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, physical address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- i_pmem_read  in  1  icache line-fill request
- i_pmem_address  in  ADDR_W  icache line address
- i_pmem_resp  out  1  icache response pulse
- i_pmem_rdata  out  LINE_W  icache fill data
- d_pmem_read  in  1  dcache line-fill request
- d_pmem_write  in  1  dcache write-back request
- d_pmem_address  in  ADDR_W  dcache line address
- d_pmem_wdata  in  LINE_W  dcache write-back data
- d_pmem_resp  out  1  dcache response pulse
- d_pmem_rdata  out  LINE_W  dcache fill data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write data
- mem_resp  in  1  memory done pulse
- mem_rdata  in  LINE_W  memory read data

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset state: FSM in ARB_IDLE. mem_read, mem_write, i_pmem_resp and d_pmem_resp are 0. Latched address, wdata and op registers are 0.
- States: ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D.
- ARB_IDLE transitions:
  - If d_pmem_read or d_pmem_write is asserted: latch d address, wdata and op; go to ARB_SERVE_D. dcache has fixed priority.
  - Else if i_pmem_read is asserted: latch i address and op=read; go to ARB_SERVE_I.
  - Else stay in ARB_IDLE.
- ARB_SERVE_x:
  - mem_read/mem_write are driven from the latched op; mem_address/mem_wdata from the latched registers.
  - The strobe stays asserted until mem_resp.
  - In the mem_resp cycle: x_pmem_resp = 1 combinationally, x_pmem_rdata = mem_rdata; next state is ARB_IDLE.
- Pulse and idle rules:
  - x_pmem_resp is asserted for exactly one cycle per transaction.
  - The non-granted resp is always 0.
  - i_pmem_rdata and d_pmem_rdata pass mem_rdata unconditionally; only resp qualifies them.
- Latency:
  - Request seen in ARB_IDLE at cycle N gives memory strobe at N+1.
  - Memory resp at cycle M gives requester resp at M; strobe drops at M+1.
  - The ARB_IDLE cycle after each transaction is mandatory, so a requester's stale request cannot be re-granted.
- Requesters hold request, address and wdata until resp. The arbiter ignores changes after the latch.
- d_pmem_read and d_pmem_write both high: illegal. Write wins and is latched as a write.
- mem_resp in ARB_IDLE is ignored; no resp is forwarded.
- A request arriving while the other requester is served waits; it is not dropped.
- rst mid-transaction: immediate return to ARB_IDLE with all strobes 0. The in-flight transaction is abandoned.

Optional Feature:
- Macro: CACHELINE_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_served register (reset = icache).
  - On simultaneous i and d requests in ARB_IDLE, grant the requester not served last.
  - Update last_served on every grant.
- Undefined: fixed dcache priority as above, and no last_served register exists.

Decomposition:
- Package cacheline_arb_pkg contains:
  - enum arb_state_t {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D};
  - enum arb_op_t {ARB_OP_READ, ARB_OP_WRITE};
  - localparams LINE_W=256 and ADDR_W=32.
- Single module. No sub-module is warranted; the FSM and latch registers are one unit.

Test Plan:
- Lone icache read: i_pmem_read=1, addr 0x0000_0040; memory resps after 5 cycles with rdata 0xAA..AA -> mem_read at N+1, mem_address 0x40, i_pmem_resp one cycle with 0xAA..AA, d_pmem_resp 0.
- Lone dcache write-back: addr 0x0000_1000, wdata 0x55..55 -> mem_write=1, mem_read=0, mem_wdata 0x55..55, d_pmem_resp one pulse.
- Simultaneous i read 0x80 and d read 0x2000:
  - Macro off -> d served first; i granted after resp plus one idle cycle, mem_address 0x80.
  - Macro on, with last_served=d -> i served first.
- Requester changes address mid-transaction (0x100 -> 0x200) -> mem_address stays 0x100 until resp.
- rst asserted during ARB_SERVE_D -> next cycle mem_read=mem_write=0, state ARB_IDLE; subsequent mem_resp yields no x_pmem_resp.
- Both d_pmem_read and d_pmem_write high -> mem_write=1, mem_read=0.

Source files
------------

// File: rtl/cacheline_arb_pkg.sv
// Shared types and widths for the cacheline arbiter.
//   arb_state_t : arbiter FSM states
//   arb_op_t    : latched memory operation
//   LINE_W      : cacheline width in bits
//   ADDR_W      : physical address width
package cacheline_arb_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        ARB_OP_READ,
        ARB_OP_WRITE
    } arb_op_t;

endpackage

// File: rtl/cacheline_arbiter.sv
// Cacheline arbiter: shares one physical-memory line port between the
// instruction cache (read-only) and the data cache (read / write-back).
// One full-line transaction is in flight at a time; the winner's request is
// latched so memory sees stable signals, and the response is routed only to
// the granted requester.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   i_pmem_read/address          icache line-fill request
//   i_pmem_resp/rdata            icache response pulse and fill data
//   d_pmem_read/write/address/wdata  dcache fill / write-back request
//   d_pmem_resp/rdata            dcache response pulse and fill data
//   mem_read/write/address/wdata memory request (from latched registers)
//   mem_resp/rdata               memory done pulse and read data
//
// Configuration:
//   CACHELINE_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests are
//   granted to the requester not served last; otherwise dcache has fixed
//   priority.
module cacheline_arbiter #(
    parameter int unsigned LINE_W = cacheline_arb_pkg::LINE_W,
    parameter int unsigned ADDR_W = cacheline_arb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata
);

    import cacheline_arb_pkg::*;

    arb_state_t        state_q, state_d;
    arb_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic d_req;
    logic i_req;
    logic grant_d;

    assign d_req = d_pmem_read | d_pmem_write;
    assign i_req = i_pmem_read;

`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
    // 0 = icache served last, 1 = dcache served last.
    logic last_served_q, last_served_d;

    assign grant_d = d_req & (~i_req | ~last_served_q);
`else
    assign grant_d = d_req;
`endif

    // Next-state and latch logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
        last_served_d = last_served_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_d) begin
                    state_d = ARB_SERVE_D;
                    // Illegal read+write is treated as a write.
                    op_d    = d_pmem_write ? ARB_OP_WRITE : ARB_OP_READ;
                    addr_d  = d_pmem_address;
                    wdata_d = d_pmem_wdata;
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
                    last_served_d = 1'b1;
`endif
                end else if (i_req) begin
                    state_d = ARB_SERVE_I;
                    op_d    = ARB_OP_READ;
                    addr_d  = i_pmem_address;
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
                    last_served_d = 1'b0;
`endif
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                // Always pass through idle so a stale request is not re-granted.
                if (mem_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            op_q    <= ARB_OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served_q <= 1'b0;
        end else begin
            last_served_q <= last_served_d;
        end
    end
`endif

    // Outputs.
    logic serving;

    assign serving = (state_q == ARB_SERVE_I) | (state_q == ARB_SERVE_D);

    always_comb begin
        mem_read    = serving & (op_q == ARB_OP_READ);
        mem_write   = serving & (op_q == ARB_OP_WRITE);
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        i_pmem_resp = (state_q == ARB_SERVE_I) & mem_resp;
        d_pmem_resp = (state_q == ARB_SERVE_D) & mem_resp;
    end

    // Read data is unqualified; resp alone marks it valid.
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter using directed vectors.
module tb_cacheline_arbiter;

    localparam int unsigned LW = 256;
    localparam int unsigned AW = 32;

    logic          clk;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic          i_pmem_resp;
    logic [LW-1:0] i_pmem_rdata;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic          d_pmem_resp;
    logic [LW-1:0] d_pmem_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic          mem_resp;
    logic [LW-1:0] mem_rdata;

    int tests;
    int fails;

    logic [LW-1:0] pat_aa;
    logic [LW-1:0] pat_55;
    logic [LW-1:0] pat_c3;

    cacheline_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0FF0;
        step();
        step();
        #1;
        tests++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: read=%b write=%b required 0 0", mem_read, mem_write);
        end
        tests++;
        if (mem_address !== 32'h0 || mem_wdata !== '0) begin
            fails++;
            $display("FAIL reset_latches: addr=%h required 0", mem_address);
        end
        i_pmem_read = 1'b0;
        rst = 1'b0;
        mem_resp = 1'b1;
        #1;
        tests++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL idle_resp_ignored: i=%b d=%b required 0 0", i_pmem_resp, d_pmem_resp);
        end
        step();
        mem_resp = 1'b0;
    endtask

    task automatic test_lone_i_read();
        int bad_wait;
        int resp_cnt;
        bad_wait = 0;
        resp_cnt = 0;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0040;
        #1;
        tests++;
        if (mem_read !== 1'b0) begin
            fails++;
            $display("FAIL i_no_strobe_at_n: mem_read=%b required 0", mem_read);
        end
        step();
        tests++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h40) begin
            fails++;
            $display("FAIL i_strobe_n1: rd=%b wr=%b addr=%h required 1 0 40",
                     mem_read, mem_write, mem_address);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            if (mem_read !== 1'b1 || i_pmem_resp !== 1'b0) bad_wait++;
        end
        tests++;
        if (bad_wait != 0) begin
            fails++;
            $display("FAIL i_hold_strobe: bad_cycles=%0d required 0", bad_wait);
        end
        step();
        mem_resp = 1'b1;
        mem_rdata = pat_aa;
        #1;
        if (i_pmem_resp === 1'b1) resp_cnt++;
        tests++;
        if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== pat_aa || d_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL i_resp: i_resp=%b d_resp=%b rdata=%h required 1 0 aa..",
                     i_pmem_resp, d_pmem_resp, i_pmem_rdata[31:0]);
        end
        step();
        mem_resp = 1'b0;
        i_pmem_read = 1'b0;
        #1;
        if (i_pmem_resp === 1'b1) resp_cnt++;
        tests++;
        if (mem_read !== 1'b0 || resp_cnt != 1) begin
            fails++;
            $display("FAIL i_done: mem_read=%b pulses=%0d required 0 1", mem_read, resp_cnt);
        end
        step();
    endtask

    task automatic test_lone_d_write();
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata = pat_55;
        step();
        tests++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h1000 ||
            mem_wdata !== pat_55) begin
            fails++;
            $display("FAIL d_write_strobe: wr=%b rd=%b addr=%h wdata=%h required 1 0 1000 55..",
                     mem_write, mem_read, mem_address, mem_wdata[31:0]);
        end
        step();
        step();
        mem_resp = 1'b1;
        mem_rdata = pat_c3;
        #1;
        tests++;
        if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL d_write_resp: d=%b i=%b required 1 0", d_pmem_resp, i_pmem_resp);
        end
        step();
        mem_resp = 1'b0;
        d_pmem_write = 1'b0;
        #1;
        tests++;
        if (mem_write !== 1'b0 || d_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL d_write_done: wr=%b d_resp=%b required 0 0", mem_write, d_pmem_resp);
        end
        step();
    endtask

    // Previous grant was dcache, so round-robin serves icache first.
    task automatic test_simultaneous();
        logic [AW-1:0] first_addr;
        logic [AW-1:0] second_addr;
        logic          first_is_d;
`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
        first_is_d  = 1'b0;
        first_addr  = 32'h0000_0080;
        second_addr = 32'h0000_2000;
`else
        first_is_d  = 1'b1;
        first_addr  = 32'h0000_2000;
        second_addr = 32'h0000_0080;
`endif
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0080;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_2000;
        step();
        tests++;
        if (mem_read !== 1'b1 || mem_address !== first_addr) begin
            fails++;
            $display("FAIL sim_first_grant: rd=%b addr=%h required 1 %h",
                     mem_read, mem_address, first_addr);
        end
        step();
        mem_resp = 1'b1;
        mem_rdata = pat_aa;
        #1;
        tests++;
        if (d_pmem_resp !== first_is_d || i_pmem_resp !== ~first_is_d) begin
            fails++;
            $display("FAIL sim_first_resp: d=%b i=%b required %b %b",
                     d_pmem_resp, i_pmem_resp, first_is_d, ~first_is_d);
        end
        step();
        mem_resp = 1'b0;
        if (first_is_d) d_pmem_read = 1'b0;
        else i_pmem_read = 1'b0;
        #1;
        tests++;
        if (mem_read !== 1'b0) begin
            fails++;
            $display("FAIL sim_idle_gap: mem_read=%b required 0", mem_read);
        end
        step();
        tests++;
        if (mem_read !== 1'b1 || mem_address !== second_addr) begin
            fails++;
            $display("FAIL sim_second_grant: rd=%b addr=%h required 1 %h",
                     mem_read, mem_address, second_addr);
        end
        step();
        mem_resp = 1'b1;
        mem_rdata = pat_55;
        #1;
        tests++;
        if (d_pmem_resp !== ~first_is_d || i_pmem_resp !== first_is_d ||
            d_pmem_rdata !== pat_55) begin
            fails++;
            $display("FAIL sim_second_resp: d=%b i=%b required %b %b",
                     d_pmem_resp, i_pmem_resp, ~first_is_d, first_is_d);
        end
        step();
        mem_resp = 1'b0;
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        step();
    endtask

    task automatic test_addr_change();
        int bad;
        bad = 0;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_0100;
        step();
        i_pmem_address = 32'h0000_0200;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (mem_address !== 32'h100 || mem_read !== 1'b1) bad++;
            step();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL addr_stable: bad_cycles=%0d addr=%h required 0 100", bad, mem_address);
        end
        mem_resp = 1'b1;
        #1;
        tests++;
        if (mem_address !== 32'h100 || i_pmem_resp !== 1'b1) begin
            fails++;
            $display("FAIL addr_at_resp: addr=%h resp=%b required 100 1", mem_address, i_pmem_resp);
        end
        step();
        mem_resp = 1'b0;
        i_pmem_read = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_3000;
        step();
        tests++;
        if (mem_read !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre: mem_read=%b required 1", mem_read);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        d_pmem_read = 1'b0;
        #1;
        tests++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_strobes: rd=%b wr=%b required 0 0", mem_read, mem_write);
        end
        mem_resp = 1'b1;
        #1;
        tests++;
        if (d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_late_resp: d=%b i=%b required 0 0", d_pmem_resp, i_pmem_resp);
        end
        step();
        mem_resp = 1'b0;
        #1;
        tests++;
        if (mem_read !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_stay_idle: mem_read=%b required 0", mem_read);
        end
        step();
    endtask

    task automatic test_both_rw();
        d_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_4000;
        d_pmem_wdata = pat_c3;
        step();
        tests++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== pat_c3) begin
            fails++;
            $display("FAIL both_rw: wr=%b rd=%b required 1 0", mem_write, mem_read);
        end
        mem_resp = 1'b1;
        #1;
        tests++;
        if (d_pmem_resp !== 1'b1) begin
            fails++;
            $display("FAIL both_rw_resp: d=%b required 1", d_pmem_resp);
        end
        step();
        mem_resp = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        pat_aa = {32{8'hAA}};
        pat_55 = {32{8'h55}};
        pat_c3 = {32{8'hC3}};
        rst = 1'b1;
        i_pmem_read = 1'b0;
        i_pmem_address = '0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata = '0;
        mem_resp = 1'b0;
        mem_rdata = '0;

        test_reset();
        test_lone_i_read();
        test_lone_d_write();
        test_simultaneous();
        test_addr_change();
        test_reset_mid();
        test_both_rw();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
